// File: rtl/hit_gate_seq_pkg.sv
// Shared types and register map constants for the hit-clock gate sequencer.
// Field addresses are derived from the counter byte width so CNT_WIDTH can change freely.
package hit_gate_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_RDY = 2'd1,
        ST_DELAY    = 2'd2,
        ST_GATE     = 2'd3
    } state_t;

    localparam int ADDR_VERSION = 0;
    localparam int ADDR_CTRL    = 1;
    localparam int ADDR_STATUS  = 2;
    localparam int ADDR_CH_EN   = 3;
    localparam int ADDR_FIELDS  = 4;

    localparam int FIELD_DELAY    = 0;
    localparam int FIELD_WIDTH    = 1;
    localparam int FIELD_REPEAT   = 2;
    localparam int FIELD_DONE_CNT = 3;

    localparam int CTRL_START      = 0;
    localparam int CTRL_RESET_HIT  = 1;
    localparam int CTRL_MODE       = 2;
    localparam int CTRL_WAIT_READY = 3;
    localparam int CTRL_STOP       = 4;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_DONE  = 1;
    localparam int STAT_READY = 2;

    // Byte address of one byte of a multi-byte field; fields are packed back to back.
    function automatic int field_addr(input int field, input int nbytes, input int byte_idx);
        return ADDR_FIELDS + field * nbytes + byte_idx;
    endfunction

endpackage

// File: rtl/hit_gate_seq_regs.sv
// Byte-wide register file for the gate sequencer: control/config registers,
// run-time shadow copies captured on START, and the registered readback mux.
module hit_gate_seq_regs
    import hit_gate_seq_pkg::*;
#(
    parameter int ABUSWIDTH = 16,
    parameter int CHANNELS  = 4,
    parameter int CNT_WIDTH = 16,
    parameter int VERSION   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rd,
    input  logic                 wr,
    input  logic [ABUSWIDTH-1:0] add,
    input  logic [7:0]           data_in,
    output logic [7:0]           data_out,
    input  logic                 busy,
    input  logic                 done,
    input  logic                 ready_sync,
    input  logic [CNT_WIDTH-1:0] done_cnt,
    input  logic                 start_acc,
    output logic                 start_req,
    output logic                 stop_req,
    output logic                 done_clr,
    output logic                 start_wait_ready,
    output logic                 reset_hit,
    output logic [CHANNELS-1:0]  sh_ch_en,
    output logic [CNT_WIDTH-1:0] sh_delay,
    output logic [CNT_WIDTH-1:0] sh_width,
    output logic [CNT_WIDTH-1:0] sh_repeat,
    output logic                 sh_mode,
    output logic                 sh_wait_ready
);

    localparam int K = CNT_WIDTH / 8;

    logic                 ctrl_mode;
    logic                 ctrl_wait_ready;
    logic [CHANNELS-1:0]  ch_en;
    logic [CNT_WIDTH-1:0] delay;
    logic [CNT_WIDTH-1:0] width;
    logic [CNT_WIDTH-1:0] repeat_cnt;
    logic [7:0]           rd_data;
    logic                 ctrl_wr;

    assign ctrl_wr          = wr && (add == ABUSWIDTH'(ADDR_CTRL));
    assign start_req        = ctrl_wr && data_in[CTRL_START];
    assign stop_req         = ctrl_wr && data_in[CTRL_STOP];
    assign start_wait_ready = data_in[CTRL_WAIT_READY];
    assign done_clr         = wr && (add == ABUSWIDTH'(ADDR_STATUS));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reset_hit       <= 1'b0;
            ctrl_mode       <= 1'b0;
            ctrl_wait_ready <= 1'b0;
            ch_en           <= '0;
            delay           <= '0;
            width           <= '0;
            repeat_cnt      <= '0;
            sh_ch_en        <= '0;
            sh_delay        <= '0;
            sh_width        <= '0;
            sh_repeat       <= '0;
            sh_mode         <= 1'b0;
            sh_wait_ready   <= 1'b0;
            data_out        <= '0;
        end else begin
            if (ctrl_wr) begin
                reset_hit       <= data_in[CTRL_RESET_HIT];
                ctrl_mode       <= data_in[CTRL_MODE];
                ctrl_wait_ready <= data_in[CTRL_WAIT_READY];
            end
            if (wr && (add == ABUSWIDTH'(ADDR_CH_EN)))
                ch_en <= data_in[CHANNELS-1:0];
            for (int i = 0; i < K; i++) begin
                if (wr && (add == ABUSWIDTH'(field_addr(FIELD_DELAY, K, i))))
                    delay[8*i +: 8] <= data_in;
                if (wr && (add == ABUSWIDTH'(field_addr(FIELD_WIDTH, K, i))))
                    width[8*i +: 8] <= data_in;
                if (wr && (add == ABUSWIDTH'(field_addr(FIELD_REPEAT, K, i))))
                    repeat_cnt[8*i +: 8] <= data_in;
            end
            // START arrives in the CTRL write itself, so mode bits come from the bus, not the register.
            if (start_acc) begin
                sh_ch_en      <= ch_en;
                sh_delay      <= delay;
                sh_width      <= width;
                sh_repeat     <= repeat_cnt;
                sh_mode       <= data_in[CTRL_MODE];
                sh_wait_ready <= data_in[CTRL_WAIT_READY];
            end
            if (rd)
                data_out <= rd_data;
        end
    end

    always_comb begin
        rd_data = '0;
        if (add == ABUSWIDTH'(ADDR_VERSION))
            rd_data = 8'(VERSION);
        if (add == ABUSWIDTH'(ADDR_CTRL)) begin
            rd_data[CTRL_RESET_HIT]  = reset_hit;
            rd_data[CTRL_MODE]       = ctrl_mode;
            rd_data[CTRL_WAIT_READY] = ctrl_wait_ready;
        end
        if (add == ABUSWIDTH'(ADDR_STATUS)) begin
            rd_data[STAT_BUSY]  = busy;
            rd_data[STAT_DONE]  = done;
            rd_data[STAT_READY] = ready_sync;
        end
        if (add == ABUSWIDTH'(ADDR_CH_EN))
            rd_data[CHANNELS-1:0] = ch_en;
        for (int i = 0; i < K; i++) begin
            if (add == ABUSWIDTH'(field_addr(FIELD_DELAY, K, i)))
                rd_data = delay[8*i +: 8];
            if (add == ABUSWIDTH'(field_addr(FIELD_WIDTH, K, i)))
                rd_data = width[8*i +: 8];
            if (add == ABUSWIDTH'(field_addr(FIELD_REPEAT, K, i)))
                rd_data = repeat_cnt[8*i +: 8];
            if (add == ABUSWIDTH'(field_addr(FIELD_DONE_CNT, K, i)))
                rd_data = done_cnt[8*i +: 8];
        end
    end

endmodule

// File: rtl/hit_gate_seq.sv
// Bus-mapped hit-clock gate sequencer: bursts of CLK_HIT_GATE after a programmable
// delay, optionally waiting for READY_HIT before each burst.
module hit_gate_seq
    import hit_gate_seq_pkg::*;
#(
    parameter int ABUSWIDTH = 16,
    parameter int CHANNELS  = 4,
    parameter int CNT_WIDTH = 16,
    parameter int VERSION   = 1
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST_N,
    input  logic                 IP_RD,
    input  logic                 IP_WR,
    input  logic [ABUSWIDTH-1:0] IP_ADD,
    input  logic [7:0]           IP_DATA_IN,
    output logic [7:0]           IP_DATA_OUT,
    input  logic                 READY_HIT,
    output logic [CHANNELS-1:0]  CLK_HIT_GATE,
    output logic                 RESET_HIT,
    output logic                 BUSY
);

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    state_t               state;
    state_t               state_nx;
    logic                 ready_meta;
    logic                 ready_sync;
    logic [CNT_WIDTH-1:0] dcnt;
    logic [CNT_WIDTH-1:0] wcnt;
    logic [CNT_WIDTH-1:0] done_cnt;
    logic                 done;

    logic                 start_req;
    logic                 stop_req;
    logic                 done_clr;
    logic                 start_wait_ready;
    logic                 start_acc;
    logic [CHANNELS-1:0]  sh_ch_en;
    logic [CNT_WIDTH-1:0] sh_delay;
    logic [CNT_WIDTH-1:0] sh_width;
    logic [CNT_WIDTH-1:0] sh_repeat;
    logic                 sh_mode;
    logic                 sh_wait_ready;

    logic [CNT_WIDTH-1:0] width_eff;
    logic [CNT_WIDTH-1:0] repeat_eff;
    logic [CNT_WIDTH-1:0] done_cnt_inc;
    logic                 delay_last;
    logic                 gate_last;
    logic                 end_of_gate;
    logic                 run_over;

    hit_gate_seq_regs #(
        .ABUSWIDTH (ABUSWIDTH),
        .CHANNELS  (CHANNELS),
        .CNT_WIDTH (CNT_WIDTH),
        .VERSION   (VERSION)
    ) u_regs (
        .clk              (BUS_CLK),
        .rst_n            (BUS_RST_N),
        .rd               (IP_RD),
        .wr               (IP_WR),
        .add              (IP_ADD),
        .data_in          (IP_DATA_IN),
        .data_out         (IP_DATA_OUT),
        .busy             (BUSY),
        .done             (done),
        .ready_sync       (ready_sync),
        .done_cnt         (done_cnt),
        .start_acc        (start_acc),
        .start_req        (start_req),
        .stop_req         (stop_req),
        .done_clr         (done_clr),
        .start_wait_ready (start_wait_ready),
        .reset_hit        (RESET_HIT),
        .sh_ch_en         (sh_ch_en),
        .sh_delay         (sh_delay),
        .sh_width         (sh_width),
        .sh_repeat        (sh_repeat),
        .sh_mode          (sh_mode),
        .sh_wait_ready    (sh_wait_ready)
    );

    assign start_acc    = start_req && !stop_req && (state == ST_IDLE);
    assign width_eff    = (sh_width == '0) ? ONE : sh_width;
    assign repeat_eff   = (sh_repeat == '0) ? ONE : sh_repeat;
    assign done_cnt_inc = (&done_cnt) ? done_cnt : done_cnt + ONE;
    assign delay_last   = (dcnt >= sh_delay);
    assign gate_last    = (wcnt >= width_eff);
    assign end_of_gate  = (state == ST_GATE) && gate_last;
    assign run_over     = !sh_mode && (done_cnt_inc >= repeat_eff);

    always_ff @(posedge BUS_CLK) begin
        if (!BUS_RST_N)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    // From IDLE the START cycle itself counts as one delay cycle; later bursts
    // re-enter the delay phase already one cycle in, so the period is DELAY+WIDTH.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:
                if (start_acc)
                    state_nx = start_wait_ready ? ST_WAIT_RDY : ST_DELAY;
            ST_WAIT_RDY:
                if (ready_sync)
                    state_nx = (sh_delay == '0) ? ST_GATE : ST_DELAY;
            ST_DELAY:
                if (delay_last)
                    state_nx = ST_GATE;
            ST_GATE:
                if (gate_last) begin
                    if (run_over)
                        state_nx = ST_IDLE;
                    else if (sh_wait_ready)
                        state_nx = ST_WAIT_RDY;
                    else if (sh_delay == '0)
                        state_nx = ST_GATE;
                    else
                        state_nx = ST_DELAY;
                end
            default:
                state_nx = ST_IDLE;
        endcase
        if (stop_req)
            state_nx = ST_IDLE;
    end

    always_comb begin
        CLK_HIT_GATE = '0;
        BUSY         = 1'b0;
        if (state == ST_GATE)
            CLK_HIT_GATE = sh_ch_en;
        if (state != ST_IDLE)
            BUSY = 1'b1;
    end

    always_ff @(posedge BUS_CLK) begin
        if (!BUS_RST_N) begin
            ready_meta <= 1'b0;
            ready_sync <= 1'b0;
            dcnt       <= '0;
            wcnt       <= '0;
            done_cnt   <= '0;
            done       <= 1'b0;
        end else begin
            ready_meta <= READY_HIT;
            ready_sync <= ready_meta;
            if (state_nx == ST_DELAY)
                dcnt <= (state == ST_DELAY) ? dcnt + ONE : ((state == ST_IDLE) ? '0 : ONE);
            if (state_nx == ST_GATE)
                wcnt <= ((state == ST_GATE) && !gate_last) ? wcnt + ONE : ONE;
            if (start_acc) begin
                done_cnt <= '0;
                done     <= 1'b0;
            end else begin
                if (end_of_gate)
                    done_cnt <= done_cnt_inc;
                if (end_of_gate && run_over && !stop_req)
                    done <= 1'b1;
                else if (done_clr)
                    done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hit_gate_seq.sv
// Self-checking bench for hit_gate_seq: directed scenarios plus randomized counted
// runs, each compared cycle by cycle against an arithmetic burst-schedule model.
module tb_hit_gate_seq;

    localparam int ABW = 16;
    localparam int CH  = 4;
    localparam int CW  = 16;
    localparam int K   = CW / 8;

    localparam int A_VERSION = 0;
    localparam int A_CTRL    = 1;
    localparam int A_STATUS  = 2;
    localparam int A_CH_EN   = 3;
    localparam int F_DELAY   = 0;
    localparam int F_WIDTH   = 1;
    localparam int F_REPEAT  = 2;
    localparam int F_DONE    = 3;
    localparam int NO_INJ    = 1 << 30;

    logic           BUS_CLK    = 1'b0;
    logic           BUS_RST_N  = 1'b0;
    logic           IP_RD      = 1'b0;
    logic           IP_WR      = 1'b0;
    logic [ABW-1:0] IP_ADD     = '0;
    logic [7:0]     IP_DATA_IN = '0;
    logic [7:0]     IP_DATA_OUT;
    logic           READY_HIT  = 1'b1;
    logic [CH-1:0]  CLK_HIT_GATE;
    logic           RESET_HIT;
    logic           BUSY;

    int n_checks = 0;
    int n_err    = 0;

    hit_gate_seq #(
        .ABUSWIDTH (ABW),
        .CHANNELS  (CH),
        .CNT_WIDTH (CW),
        .VERSION   (1)
    ) dut (
        .BUS_CLK      (BUS_CLK),
        .BUS_RST_N    (BUS_RST_N),
        .IP_RD        (IP_RD),
        .IP_WR        (IP_WR),
        .IP_ADD       (IP_ADD),
        .IP_DATA_IN   (IP_DATA_IN),
        .IP_DATA_OUT  (IP_DATA_OUT),
        .READY_HIT    (READY_HIT),
        .CLK_HIT_GATE (CLK_HIT_GATE),
        .RESET_HIT    (RESET_HIT),
        .BUSY         (BUSY)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr_reg(input int a, input int d);
        @(negedge BUS_CLK);
        IP_WR      = 1'b1;
        IP_ADD     = ABW'(a);
        IP_DATA_IN = 8'(d);
        @(negedge BUS_CLK);
        IP_WR      = 1'b0;
    endtask

    task automatic rd_reg(input int a, output logic [7:0] v);
        @(negedge BUS_CLK);
        IP_RD  = 1'b1;
        IP_ADD = ABW'(a);
        @(negedge BUS_CLK);
        IP_RD  = 1'b0;
        v      = IP_DATA_OUT;
    endtask

    task automatic wr_field(input int field, input int val);
        for (int i = 0; i < K; i++)
            wr_reg(4 + field * K + i, (val >> (8 * i)) & 255);
    endtask

    task automatic rd_field(input int field, output int val);
        logic [7:0] b;
        val = 0;
        for (int i = 0; i < K; i++) begin
            rd_reg(4 + field * K + i, b);
            val = val | (int'(b) << (8 * i));
        end
    endtask

    // Program a run and issue START; returns mid-cycle right after the START edge.
    task automatic start_run(input int ch, input int d, input int w, input int r, input int ctrl);
        wr_reg(A_CH_EN, ch);
        wr_field(F_DELAY, d);
        wr_field(F_WIDTH, w);
        wr_field(F_REPEAT, r);
        wr_reg(A_CTRL, ctrl | 1);
    endtask

    // Burst schedule: gate n (0-based) covers cycles 1+d+n*(d+w) .. +w-1 after START.
    function automatic bit model_gate(input int k, input int d, input int w, input int rep);
        int off;
        if (k < 1 + d) return 1'b0;
        off = k - 1 - d;
        return ((off % (d + w)) < w) && ((off / (d + w)) < rep);
    endfunction

    function automatic bit model_gate_end(input int k, input int d, input int w, input int rep);
        int off;
        if (k < 1 + d) return 1'b0;
        off = k - 1 - d;
        return ((off % (d + w)) == w - 1) && ((off / (d + w)) < rep);
    endfunction

    // Compare gates and BUSY for n cycles after START. A single bus write can be
    // injected at cycle inj_k; stop_k is the first cycle where the run is expected stopped.
    task automatic trace(input string name, input int n, input int d, input int w_raw, input int r_raw,
                         input int ch, input bit cont, input int inj_k, input int inj_a,
                         input int inj_d, input int stop_k, output int exp_done);
        int w, rep, last;
        bit eg, eb;
        w    = (w_raw == 0) ? 1 : w_raw;
        rep  = cont ? (1 << 20) : ((r_raw == 0) ? 1 : r_raw);
        last = d + (rep - 1) * (d + w) + w;
        exp_done = 0;
        for (int k = 1; k <= n; k++) begin
            @(negedge BUS_CLK);
            eg = model_gate(k, d, w, rep) && (k < stop_k);
            eb = (k <= last) && (k < stop_k);
            if (model_gate_end(k, d, w, rep) && (k < stop_k)) exp_done++;
            chk($sformatf("%s gate k=%0d", name, k), 32'(CLK_HIT_GATE), eg ? 32'(ch) : 32'd0);
            chk($sformatf("%s busy k=%0d", name, k), 32'(BUSY), 32'(eb));
            if (k == inj_k) begin
                IP_WR      = 1'b1;
                IP_ADD     = ABW'(inj_a);
                IP_DATA_IN = 8'(inj_d);
            end else begin
                IP_WR = 1'b0;
            end
        end
        IP_WR = 1'b0;
    endtask

    initial begin
        logic [7:0] v;
        int         cnt;
        int         exp_done;
        int         d, w, r, ch, rep, n;

        // Reset with READY_HIT high, then release with READY_HIT low.
        BUS_RST_N = 1'b0;
        READY_HIT = 1'b1;
        repeat (2) @(posedge BUS_CLK);
        @(negedge BUS_CLK);
        chk("reset gates", 32'(CLK_HIT_GATE), 32'd0);
        chk("reset busy", 32'(BUSY), 32'd0);
        chk("reset reset_hit", 32'(RESET_HIT), 32'd0);
        chk("reset data_out", 32'(IP_DATA_OUT), 32'd0);
        BUS_RST_N = 1'b1;
        READY_HIT = 1'b0;
        for (int a = 0; a < 4 + 4 * K; a++) begin
            rd_reg(a, v);
            chk($sformatf("reset reg%0d", a), 32'(v), (a == A_VERSION) ? 32'd1 : 32'd0);
        end

        // RESET_HIT is a plain level from CTRL bit1.
        wr_reg(A_CTRL, 8'h02);
        chk("reset_hit set", 32'(RESET_HIT), 32'd1);
        rd_reg(A_CTRL, v);
        chk("ctrl readback", 32'(v), 32'h02);
        wr_reg(A_CTRL, 8'h00);
        chk("reset_hit clr", 32'(RESET_HIT), 32'd0);

        // Counted run.
        start_run(5, 3, 2, 3, 0);
        trace("counted", 18, 3, 2, 3, 5, 1'b0, NO_INJ, 0, 0, NO_INJ, exp_done);
        rd_reg(A_STATUS, v);
        chk("counted status", 32'(v), 32'h02);
        rd_field(F_DONE, cnt);
        chk("counted done_cnt", 32'(cnt), 32'(exp_done));
        rd_reg(A_CTRL, v);
        chk("ctrl strobes read 0", 32'(v), 32'h00);

        // Zero-length fields, then clear DONE by writing STATUS.
        start_run(4'hA, 0, 0, 0, 0);
        trace("zero", 4, 0, 0, 0, 4'hA, 1'b0, NO_INJ, 0, 0, NO_INJ, exp_done);
        rd_field(F_DONE, cnt);
        chk("zero done_cnt", 32'(cnt), 32'd1);
        wr_reg(A_STATUS, 8'hFF);
        rd_reg(A_STATUS, v);
        chk("done cleared", 32'(v), 32'h00);

        // Continuous mode stopped after the 10th gate.
        start_run(4'h3, 1, 1, 0, 8'h04);
        trace("cont", 24, 1, 1, 0, 4'h3, 1'b1, 20, A_CTRL, 8'h10, 21, exp_done);
        rd_reg(A_STATUS, v);
        chk("cont status", 32'(v), 32'h00);
        rd_field(F_DONE, cnt);
        chk("cont done_cnt", 32'(cnt), 32'(exp_done));

        // WIDTH rewritten mid-run: only the next run sees it.
        start_run(4'h9, 2, 1, 3, 0);
        trace("rewrite", 12, 2, 1, 3, 4'h9, 1'b0, 1, 4 + F_WIDTH * K, 9, NO_INJ, exp_done);
        wr_reg(A_CTRL, 8'h01);
        trace("next run", 36, 2, 9, 3, 4'h9, 1'b0, NO_INJ, 0, 0, NO_INJ, exp_done);

        // START together with STOP from IDLE does nothing.
        wr_reg(A_CTRL, 8'h11);
        for (int k = 1; k <= 3; k++) begin
            @(negedge BUS_CLK);
            chk($sformatf("start+stop busy k=%0d", k), 32'(BUSY), 32'd0);
            chk($sformatf("start+stop gate k=%0d", k), 32'(CLK_HIT_GATE), 32'd0);
        end

        // Randomized counted runs.
        for (int it = 0; it < 6; it++) begin
            d   = $urandom_range(0, 4);
            w   = $urandom_range(0, 3);
            r   = $urandom_range(0, 3);
            ch  = $urandom_range(1, 15);
            rep = (r == 0) ? 1 : r;
            n   = d + (rep - 1) * (d + ((w == 0) ? 1 : w)) + ((w == 0) ? 1 : w) + 3;
            start_run(ch, d, w, r, 0);
            trace($sformatf("rand%0d", it), n, d, w, r, ch, 1'b0, NO_INJ, 0, 0, NO_INJ, exp_done);
            rd_field(F_DONE, cnt);
            chk($sformatf("rand%0d done_cnt", it), 32'(cnt), 32'(exp_done));
        end

        // Handshake: hold READY low 20 cycles, first gate DELAY+3 after the rise.
        start_run(4'h3, 2, 1, 1, 8'h08);
        for (int k = 1; k <= 20; k++) begin
            @(negedge BUS_CLK);
            chk($sformatf("hs wait gate k=%0d", k), 32'(CLK_HIT_GATE), 32'd0);
            chk($sformatf("hs wait busy k=%0d", k), 32'(BUSY), 32'd1);
        end
        READY_HIT = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            @(negedge BUS_CLK);
            chk($sformatf("hs gate j=%0d", j), 32'(CLK_HIT_GATE), (j == 5) ? 32'h3 : 32'd0);
            chk($sformatf("hs busy j=%0d", j), 32'(BUSY), (j <= 5) ? 32'd1 : 32'd0);
        end
        rd_reg(A_STATUS, v);
        chk("hs status", 32'(v), 32'h06);

        // Reset applied during GATE drops gates at that edge.
        start_run(4'hF, 1, 5, 1, 0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge BUS_CLK);
            chk($sformatf("rst-run gate k=%0d", k), 32'(CLK_HIT_GATE), (k >= 2) ? 32'hF : 32'd0);
        end
        BUS_RST_N = 1'b0;
        @(negedge BUS_CLK);
        BUS_RST_N = 1'b1;
        chk("mid-gate reset gates", 32'(CLK_HIT_GATE), 32'd0);
        chk("mid-gate reset busy", 32'(BUSY), 32'd0);
        @(negedge BUS_CLK);
        chk("after reset idle", 32'(BUSY), 32'd0);
        rd_reg(A_CH_EN, v);
        chk("after reset ch_en", 32'(v), 32'd0);
        rd_field(F_DELAY, cnt);
        chk("after reset delay", 32'(cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/hit_gate_seq.md
Name: hit_gate_seq

Overview:
- Bus-mapped successor to the single-bit CLK_HIT gate and RESET_HIT status register in the simulation top.
- Generates a programmable sequence of hit-clock gate bursts on CHANNELS independent gate outputs.
- Each burst has its own delay, width and repeat count. Optional handshake waits on the READY_HIT line. Bursts-done counter and status are readable.
- Sits behind bus_to_ip in the testbench top. Drives CLK_HIT_GATE[n] and RESET_HIT toward the hit-stimulus model.

Parameters:
- ABUSWIDTH, 16, IP address width.
- CHANNELS, 4, number of gate outputs (1..8).
- CNT_WIDTH, 16, width of delay/width/repeat/done counters (multiple of 8, 8..32).
- VERSION, 1, value returned at register 0.

Ports:
- BUS_CLK  in  1  bus clock; the only clock.
- BUS_RST_N  in  1  reset, synchronous, active-low.
- IP_RD  in  1  read strobe, one cycle.
- IP_WR  in  1  write strobe, one cycle.
- IP_ADD  in  ABUSWIDTH  register address (offset from BASEADDR).
- IP_DATA_IN  in  8  write data.
- IP_DATA_OUT  out  8  read data, registered.
- READY_HIT  in  1  asynchronous ready from hit model.
- CLK_HIT_GATE  out  CHANNELS  per-channel gate for CLK_HIT.
- RESET_HIT  out  1  hit-model reset level.
- BUSY  out  1  sequence active.

Behaviour:
- Reset: one clock, synchronous, active-low (BUS_RST_N low at a BUS_CLK edge).
  - At the next edge, all registers and counters go to 0, FSM goes to IDLE.
  - Outputs: CLK_HIT_GATE=0, RESET_HIT=0, BUSY=0, IP_DATA_OUT=0.
  - A reset mid-burst drops the gates at that same edge.
- Register map (byte-wide; multi-byte fields little-endian, K=CNT_WIDTH/8 bytes each):
  - 0 VERSION (RO).
  - 1 CTRL: bit0 START (write-strobe), bit1 RESET_HIT level, bit2 MODE (0 counted, 1 continuous), bit3 WAIT_READY, bit4 STOP (write-strobe). Strobe bits read back 0.
  - 2 STATUS (RO except DONE): bit0 BUSY, bit1 DONE, bit2 READY_SYNC. Writing any value to 2 clears DONE.
  - 3 CH_EN[CHANNELS-1:0].
  - 4.. DELAY (K bytes), then WIDTH (K bytes), then REPEAT (K bytes), then DONE_CNT (K bytes, RO).
- Reads: IP_DATA_OUT is updated on the edge where IP_RD=1 and holds otherwise. Unmapped addresses return 0.
- READY_HIT is synchronised through 2 flops (READY_SYNC), giving 2 cycles of latency.
- On START accepted in IDLE:
  - DELAY, WIDTH, REPEAT, CH_EN, MODE and WAIT_READY are copied into shadow registers. Writes during BUSY affect only the next run.
  - DONE_CNT and DONE are cleared. BUSY=1 from the next cycle.
- FSM:
  - IDLE -> (START) -> WAIT_RDY if WAIT_READY, else DELAY.
  - WAIT_RDY -> DELAY when READY_SYNC=1.
  - DELAY: stays exactly DELAY cycles; 0 means it is skipped (passes through in 1 cycle).
  - GATE: CLK_HIT_GATE = CH_EN shadow for exactly max(WIDTH,1) cycles.
  - At the end of GATE, DONE_CNT increments (saturating at all-ones). Then:
    - MODE=1 -> back to WAIT_RDY/DELAY.
    - MODE=0 and DONE_CNT < max(REPEAT,1) -> back to WAIT_RDY/DELAY.
    - Otherwise -> IDLE with DONE=1.
- Timing with WAIT_READY=0 and START written at edge t: the first gate cycle is the edge t+1+DELAY.
- Gate-to-gate period is DELAY+WIDTH cycles; there is no idle gap cycle.
- STOP:
  - Accepted in any state: goes to IDLE at the next edge, gates 0, DONE unchanged.
  - START and STOP in the same write: STOP wins.
  - START while BUSY is ignored.
- Continuous mode runs until STOP or reset. DONE_CNT still counts.
- RESET_HIT follows the CTRL bit1 register directly, independent of the FSM.

Decomposition:
- Package hit_gate_seq_pkg holds:
  - the state enum (IDLE, WAIT_RDY, DELAY, GATE);
  - register address constants;
  - CTRL bit-index constants.
- One natural sub-module: hit_gate_seq_regs (register file, shadow capture, readback mux).
- The FSM and counters stay in the top.

Test Plan:
- Reset check: hold BUS_RST_N low 2 cycles with READY_HIT=1 -> gates=0, BUSY=0, every register reads 0 except VERSION=1.
- Counted run: CH_EN=0x5, DELAY=3, WIDTH=2, REPEAT=3, START at edge t -> CLK_HIT_GATE=0x5 on edges t+4..t+5, t+9..t+10 and t+14..t+15. DONE=1 and DONE_CNT=3 afterwards, BUSY falls the cycle after the last gate.
- Zero-length fields: DELAY=0, WIDTH=0, REPEAT=0 -> exactly one gate pulse of 1 cycle at t+1, DONE_CNT=1.
- Handshake: WAIT_READY=1, READY_HIT=0 for 20 cycles then 1 -> no gate before the READY rise; first gate DELAY+3 cycles after the rise.
- Continuous mode plus STOP: MODE=1, DELAY=1, WIDTH=1, STOP written after 10 gates -> gates 0 from the next edge, DONE=0, DONE_CNT=10. START and STOP in one write from IDLE -> stays IDLE.
- Robustness: rewrite WIDTH=9 mid-run -> the current run keeps its old width. Apply BUS_RST_N low during GATE -> gates 0 at that edge, FSM in IDLE.
